// File: rtl/reg_enable_sequencer.sv
// -----------------------------------------------------------------------------
// reg_enable_sequencer
//
// Converts a 5-bit register index into a one-hot 32-bit register-file enable.
// It runs a burst of consecutive indices, ascending or descending with modulo
// wrap, for block load/store and context save/restore. One enable is issued
// per accepted beat. The output index is the exact inverse of the datapath's
// 32-to-5 priority encoder.
//
// Handshake: the beat in dout/cur_idx is live while dout_valid = 1 and stays
// stable until an edge where ready = 1, which accepts it. start is sampled
// only in IDLE and is dropped, not queued, while a burst runs.
//
// Ports:
//   clk         rising-edge clock
//   clr_n       asynchronous active-low reset
//   start       request a burst (sampled only in IDLE)
//   start_idx   first register index of the burst
//   count       burst length minus one
//   dir         0 = ascending, 1 = descending (latched at start)
//   ready       consumer accepts the current beat
//   skip_mask   (only with REG_SKIP_MASK_EN) indices skipped without a beat
//   dout        one-hot enable, all zero when no beat is live
//   dout_valid  dout holds a live beat
//   cur_idx     index of the current (or last) beat
//   busy        burst in progress
//   done        one-cycle pulse after the final beat is accepted
//   dbg_state   FSM state for observation (0 = IDLE, 1 = RUN)
//
// Optional feature macro: REG_SKIP_MASK_EN
//   Defined   : adds skip_mask. A masked index shows no beat and advances
//               without waiting for ready.
//   Undefined : every index in the burst produces a beat.
//
// N_OUT must equal 2**IDX_W.
// -----------------------------------------------------------------------------
module reg_enable_sequencer #(
   parameter int N_OUT = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic [IDX_W-1:0] start_idx,
   input  logic [IDX_W-1:0] count,
   input  logic             dir,
   input  logic             ready,
`ifdef REG_SKIP_MASK_EN
   input  logic [N_OUT-1:0] skip_mask,
`endif
   output logic [N_OUT-1:0] dout,
   output logic             dout_valid,
   output logic [IDX_W-1:0] cur_idx,
   output logic             busy,
   output logic             done,
   output logic             dbg_state
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [IDX_W-1:0] rem_q,   rem_d;
   logic             dir_q,   dir_d;
   logic             done_q,  done_d;
   logic [N_OUT-1:0] dout_q,  dout_d;

   logic             skip_hit;
   logic             advance;

`ifdef REG_SKIP_MASK_EN
   // The mask is a quasi-static configuration input. It is applied to the
   // current index in the same cycle, so this is the only input-to-output path.
   assign skip_hit = (state_q == RUN) && skip_mask[idx_q];
`else
   assign skip_hit = 1'b0;
`endif

   // A masked beat advances without waiting for the consumer.
   assign advance = ready | skip_hit;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d   = start_idx;
               rem_d   = count;
               dir_d   = dir;
               state_d = RUN;
            end
         end
         RUN: begin
            if (advance) begin
               if (rem_q == '0) begin
                  // cur_idx keeps the last index after completion.
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  // IDX_W-bit arithmetic gives the 31 -> 0 and 0 -> 31 wrap.
                  idx_d = dir_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
                  rem_d = rem_q - IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The one-hot enable is decoded ahead of the edge, so dout is a
      // register output and not a decode of the index register.
      dout_d = (state_d == RUN) ? (N_OUT'(1) << idx_d) : '0;
   end

   assign busy       = (state_q == RUN);
   assign dout_valid = busy & ~skip_hit;
   assign dout       = skip_hit ? '0 : dout_q;
   assign cur_idx    = idx_q;
   assign done       = done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_reg_enable_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_enable_sequencer
//
// Bench for reg_enable_sequencer in the default build (REG_SKIP_MASK_EN
// undefined). Inputs change on the falling edge and outputs are checked on
// the next falling edge.
// -----------------------------------------------------------------------------
module tb_reg_enable_sequencer;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        clr_n;
   logic        start;
   logic [4:0]  start_idx;
   logic [4:0]  count;
   logic        dir;
   logic        ready;
   logic [31:0] dout;
   logic        dout_valid;
   logic [4:0]  cur_idx;
   logic        busy;
   logic        done;
   logic        dbg_state;

   always #5 clk = ~clk;

   reg_enable_sequencer #(.N_OUT(32), .IDX_W(5)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .start      (start),
      .start_idx  (start_idx),
      .count      (count),
      .dir        (dir),
      .ready      (ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .cur_idx    (cur_idx),
      .busy       (busy),
      .done       (done),
      .dbg_state  (dbg_state)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // ---------------------------------------------------------------- reference model
   // A burst is the list of indices it still has to issue. The head of the list
   // is the live beat, and an empty list means idle.
   int   exp_q[$];
   int   m_last = 0;
   logic m_done = 1'b0;

   function automatic void model_reset();
      exp_q.delete();
      m_last = 0;
      m_done = 1'b0;
   endfunction

   function automatic void model_edge(logic st, int si, int cnt, logic d, logic r);
      m_done = 1'b0;
      if (exp_q.size() > 0) begin
         if (r) begin
            m_last = exp_q.pop_front();
            if (exp_q.size() == 0) m_done = 1'b1;
         end
      end else if (st) begin
         for (int k = 0; k <= cnt; k++)
            exp_q.push_back((si + (d ? 32 - k : k)) % 32);
      end
   endfunction

   // ---------------------------------------------------------------- scoreboard
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_vals(input string tag, input logic [31:0] e_dout, input logic e_valid,
                             input logic [4:0] e_idx, input logic e_busy, input logic e_done);
      chk({tag, ".dout"},       dout,             e_dout);
      chk({tag, ".dout_valid"}, 32'(dout_valid),  32'(e_valid));
      chk({tag, ".cur_idx"},    32'(cur_idx),     32'(e_idx));
      chk({tag, ".busy"},       32'(busy),        32'(e_busy));
      chk({tag, ".done"},       32'(done),        32'(e_done));
      chk({tag, ".dbg_state"},  32'(dbg_state),   32'(e_busy));
   endtask

   task automatic check_model(input string tag);
      logic        b;
      logic [31:0] d;
      logic [4:0]  i;
      b = (exp_q.size() > 0);
      d = 32'h0;
      if (b) d[exp_q[0]] = 1'b1;
      i = b ? 5'(exp_q[0]) : 5'(m_last);
      check_vals(tag, d, b, i, b, m_done);
   endtask

   // ---------------------------------------------------------------- driver
   task automatic step(input logic st, input logic [4:0] si, input logic [4:0] cnt,
                       input logic d, input logic r);
      start     = st;
      start_idx = si;
      count     = cnt;
      dir       = d;
      ready     = r;
      @(posedge clk);
      model_edge(st, int'(si), int'(cnt), d, r);
      @(negedge clk);
   endtask

   // Asserted away from the clock edge to show the reset is asynchronous.
   task automatic async_reset(input string tag);
      clr_n = 1'b0;
      #1;
      model_reset();
      check_vals({tag, ".in_reset"}, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   // ---------------------------------------------------------------- vector table
   typedef struct {
      logic        st;
      logic [4:0]  si;
      logic [4:0]  cnt;
      logic        d;
      logic        r;
      logic [31:0] e_dout;
      logic        e_valid;
      logic [4:0]  e_idx;
      logic        e_busy;
      logic        e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic st, logic [4:0] si, logic [4:0] cnt, logic d, logic r,
                               logic [31:0] ed, logic ev, logic [4:0] ei, logic eb, logic edn);
      vec_t v;
      v.st = st; v.si = si; v.cnt = cnt; v.d = d; v.r = r;
      v.e_dout = ed; v.e_valid = ev; v.e_idx = ei; v.e_busy = eb; v.e_done = edn;
      vecs.push_back(v);
   endfunction

   // ---------------------------------------------------------------- watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
      $fatal(1, "time limit");
   end

   // ---------------------------------------------------------------- test
   initial begin
      // Single beat at index 7
      add(1, 7,  0, 0, 1, 32'h0000_0080, 1, 7,  1, 0);
      add(0, 0,  0, 0, 1, 32'h0000_0000, 0, 7,  0, 1);
      add(0, 0,  0, 0, 1, 32'h0000_0000, 0, 7,  0, 0);
      // Ascending wrap 30,31,0,1
      add(1, 30, 3, 0, 1, 32'h4000_0000, 1, 30, 1, 0);
      add(0, 0,  0, 0, 1, 32'h8000_0000, 1, 31, 1, 0);
      add(0, 0,  0, 0, 1, 32'h0000_0001, 1, 0,  1, 0);
      add(0, 0,  0, 0, 1, 32'h0000_0002, 1, 1,  1, 0);
      add(0, 0,  0, 0, 1, 32'h0000_0000, 0, 1,  0, 1);
      add(0, 0,  0, 0, 0, 32'h0000_0000, 0, 1,  0, 0);
      // Descending with stalls 1,0,31; ready 0,1,0,0,1,1
      add(1, 1,  2, 1, 0, 32'h0000_0002, 1, 1,  1, 0);
      add(0, 0,  0, 0, 0, 32'h0000_0002, 1, 1,  1, 0);
      add(0, 0,  0, 0, 1, 32'h0000_0001, 1, 0,  1, 0);
      add(0, 0,  0, 0, 0, 32'h0000_0001, 1, 0,  1, 0);
      add(0, 0,  0, 0, 0, 32'h0000_0001, 1, 0,  1, 0);
      add(0, 0,  0, 0, 1, 32'h8000_0000, 1, 31, 1, 0);
      add(0, 0,  0, 0, 1, 32'h0000_0000, 0, 31, 0, 1);
      add(0, 0,  0, 0, 0, 32'h0000_0000, 0, 31, 0, 0);
      // Start while busy is ignored; start in the done cycle is taken
      add(1, 0,  3, 0, 1, 32'h0000_0001, 1, 0,  1, 0);
      add(1, 20, 0, 0, 1, 32'h0000_0002, 1, 1,  1, 0);
      add(1, 20, 0, 1, 1, 32'h0000_0004, 1, 2,  1, 0);
      add(0, 0,  0, 0, 1, 32'h0000_0008, 1, 3,  1, 0);
      add(0, 0,  0, 0, 1, 32'h0000_0000, 0, 3,  0, 1);
      add(1, 5,  0, 0, 1, 32'h0000_0020, 1, 5,  1, 0);
      add(0, 0,  0, 0, 1, 32'h0000_0000, 0, 5,  0, 1);
      add(0, 0,  0, 0, 1, 32'h0000_0000, 0, 5,  0, 0);

      clr_n = 1'b0; start = 0; start_idx = 0; count = 0; dir = 0; ready = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check_vals("reset", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      clr_n = 1'b1;
      @(negedge clk);

      // Reset asserted mid-cycle while a burst runs
      step(1, 9, 5, 0, 1);
      step(0, 0, 0, 0, 1);
      check_model("pre_reset");
      async_reset("mid_cycle_reset");

      // Directed vector table
      foreach (vecs[k]) begin
         step(vecs[k].st, vecs[k].si, vecs[k].cnt, vecs[k].d, vecs[k].r);
         check_vals($sformatf("vec%0d", k), vecs[k].e_dout, vecs[k].e_valid,
                    vecs[k].e_idx, vecs[k].e_busy, vecs[k].e_done);
      end

      // Reset after the 2nd beat of an 8-beat burst: no done pulse follows
      step(1, 10, 7, 0, 1);
      step(0, 0, 0, 0, 1);
      check_model("burst8.beat2");
      async_reset("burst8_reset");
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 1);
         check_model($sformatf("burst8.after%0d", k));
      end
      step(1, 3, 1, 1, 1);
      check_model("post_reset.beat0");
      step(0, 0, 0, 0, 1);
      check_model("post_reset.beat1");
      step(0, 0, 0, 0, 1);
      check_model("post_reset.done");

      // Full 32-beat burst with occasional stalls visits every index once
      step(1, 13, 31, 1, 1);
      check_model("full.start");
      for (int k = 0; k < 80 && exp_q.size() > 0; k++) begin
         step(0, 0, 0, 0, ($urandom_range(0, 3) != 0));
         check_model("full.run");
      end
      chk("full.finished", 32'(exp_q.size()), 32'd0);

      // Random traffic against the list model
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset("rand_reset");
         end
         step(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
              ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
         check_model("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/reg_enable_sequencer.md
Name: reg_enable_sequencer

Overview:
- Decode direction for register-file select: turns a 5-bit register index into a one-hot 32-bit register enable.
- Runs a burst of consecutive indices, one enable per accepted beat, for multi-register transfers (block load/store, context save/restore).
- Sits between the control unit and the register-file enable lines.
- Output index is the exact inverse of the datapath's 32-to-5 priority encoder.

Parameters:
- N_OUT, 32, width of one-hot output; must equal 2**IDX_W.
- IDX_W, 5, width of register index and of count field.

Ports:
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low reset
- start  input  1  request a burst; sampled only in IDLE
- start_idx  input  IDX_W  first register index of the burst
- count  input  IDX_W  burst length minus one (0 -> 1 beat, 31 -> 32 beats)
- dir  input  1  0 = ascending index, 1 = descending; latched at start
- ready  input  1  consumer accepts current beat
- dout  output  N_OUT  one-hot enable; bit cur_idx set while dout_valid, else all zero
- dout_valid  output  1  dout holds a live beat
- cur_idx  output  IDX_W  index of current beat
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset (clr_n low, asynchronous, any state): state = IDLE; dout = 0, dout_valid = 0, cur_idx = 0, busy = 0, done = 0; latched dir and remaining count cleared. Any burst in progress is abandoned with no done pulse.
- Registered outputs only; no combinational path from inputs to outputs.
- IDLE:
  - start = 1 at an edge: latch idx = start_idx, rem = count, dir; go to RUN.
  - First beat visible the cycle after the start edge (latency 1).
  - done is low in IDLE except for its pulse cycle.
- RUN:
  - busy = 1, dout_valid = 1, dout = 1 << cur_idx.
  - Beat accepted at an edge where ready = 1.
  - ready = 0: hold dout, cur_idx and rem unchanged indefinitely.
  - Accepted with rem != 0: cur_idx = cur_idx + 1 (dir = 0) or cur_idx - 1 (dir = 1), modulo 32. Wrap 31 -> 0 and 0 -> 31 is legal. rem decrements.
  - Accepted with rem == 0: go to IDLE. The following cycle: done = 1, busy = 0, dout_valid = 0, dout = 0. cur_idx holds the last index.
- start during RUN is ignored and not queued.
- start is accepted in the same cycle done is high, since the state is already IDLE. Back-to-back bursts therefore have exactly one idle cycle between them.
- Invariant: when dout_valid = 1, dout is exactly one-hot and encodes to cur_idx through the 32-to-5 encoder.
- A 32-beat burst visits every index exactly once.

Optional Feature:
- Macro: REG_SKIP_MASK_EN.
- Defined:
  - Adds input skip_mask [N_OUT-1:0], sampled every cycle in RUN.
  - If skip_mask[cur_idx] = 1: dout = 0 and dout_valid = 0 that cycle. The beat advances (index step, rem decrement, or completion) without waiting for ready.
  - A burst whose indices are all masked still completes and pulses done.
- Undefined:
  - Port absent; every index in the burst produces a beat.

Test Plan:
- Reset: assert clr_n low mid-cycle -> all outputs 0 immediately. Release, then start with start_idx = 7, count = 0, ready = 1 -> one cycle dout = 0x00000080 with cur_idx = 7, next cycle done = 1, busy = 0.
- Ascending wrap: start_idx = 30, count = 3, dir = 0, ready = 1 -> dout sequence 0x40000000, 0x80000000, 0x00000001, 0x00000002, then done pulse.
- Descending with stalls: start_idx = 1, count = 2, dir = 1, ready toggling 0,1,0,0,1,1 -> beats 0x2, 0x1, 0x80000000, each held while ready = 0, done after third acceptance.
- Start while busy: second start (start_idx = 20) during burst of 4 beats from 0 -> ignored, indices 0..3 only. Start asserted in done cycle -> accepted, first beat appears the next cycle.
- Reset mid-burst: clr_n low after 2nd beat of 8-beat burst -> dout = 0, busy = 0, no done pulse. New start after release behaves normally.
- REG_SKIP_MASK_EN: start_idx = 0, count = 3, skip_mask = 0x00000006 -> valid beats only at idx 0 and 3, dout_valid low at idx 1 and 2, done pulse after idx 3.
